// File: rtl/vga_sync_monitor_if.sv
// Pin-level bundle between the VGA display path (master) and vga_sync_monitor (slave):
// monitored sync/colour pins, probe coordinate, and the recovered status outputs.
interface vga_sync_monitor_if;
   logic        hsync;
   logic        vsync;
   logic [11:0] rgb;
   logic [9:0]  probe_x;
   logic [9:0]  probe_y;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        pix_stb;
   logic        de;
   logic        locked;
   logic        h_err;
   logic        v_err;
   logic [7:0]  err_cnt;
   logic [15:0] frame_cnt;
   logic [11:0] probe_rgb;
   logic        probe_valid;
   logic [15:0] frame_crc;

   modport master (
      output hsync, vsync, rgb, probe_x, probe_y,
      input  x, y, pix_stb, de, locked, h_err, v_err, err_cnt, frame_cnt,
             probe_rgb, probe_valid, frame_crc
   );

   modport slave (
      input  hsync, vsync, rgb, probe_x, probe_y,
      output x, y, pix_stb, de, locked, h_err, v_err, err_cnt, frame_cnt,
             probe_rgb, probe_valid, frame_crc
   );
endinterface

// File: rtl/vga_sync_monitor.sv
// Recovers pixel coordinates from monitored VGA sync pins, checks line/frame timing and tracks lock.
// Optional per-frame CRC of active pixels is built only when VGA_MON_CRC_EN is defined.
module vga_sync_monitor #(
   parameter int H_DISP        = 640,
   parameter int H_FP          = 16,
   parameter int H_SYNC        = 96,
   parameter int H_BP          = 48,
   parameter int V_DISP        = 480,
   parameter int V_FP          = 10,
   parameter int V_SYNC        = 2,
   parameter int V_BP          = 33,
   parameter int CLK_PER_PIXEL = 4,
   parameter int LOCK_FRAMES   = 2
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   vga_sync_monitor_if.slave bus
);

   localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int PH_W    = (CLK_PER_PIXEL > 2) ? $clog2(CLK_PER_PIXEL) : 1;

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_PER_PIXEL - 1);
   localparam logic [PH_W-1:0] PH_MID  = PH_W'(CLK_PER_PIXEL / 2);
   localparam logic [9:0]      X_DISP  = 10'(H_DISP);
   localparam logic [9:0]      X_SYNC  = 10'(H_DISP + H_FP);
   localparam logic [9:0]      X_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0]      Y_DISP  = 10'(V_DISP);
   localparam logic [9:0]      Y_SYNC  = 10'(V_DISP + V_FP);
   localparam logic [9:0]      Y_LAST  = 10'(V_TOTAL - 1);
   localparam logic [15:0]     H_PER_C = 16'(H_TOTAL * CLK_PER_PIXEL);
   localparam logic [15:0]     H_LOW_C = 16'(H_SYNC * CLK_PER_PIXEL);
   localparam logic [15:0]     V_TOT_C = 16'(V_TOTAL);
   localparam logic [15:0]     V_LOW_C = 16'(V_SYNC);
   localparam logic [7:0]      LOCK_C  = 8'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // ---- stage p0/p1: input registers and edge detect ----
   logic        r_hs_p0, r_hs_p1;
   logic        r_vs_p0, r_vs_p1;
   logic [11:0] r_rgb_p0;
   logic        w_hs_fall, w_vs_fall;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_hs_p0 <= 1'b1;
         r_hs_p1 <= 1'b1;
         r_vs_p0 <= 1'b1;
         r_vs_p1 <= 1'b1;
      end else begin
         r_hs_p0 <= bus.hsync;
         r_hs_p1 <= r_hs_p0;
         r_vs_p0 <= bus.vsync;
         r_vs_p1 <= r_vs_p0;
      end
   end

   always_ff @(posedge sys_clk) begin
      r_rgb_p0 <= bus.rgb;
   end

   assign w_hs_fall = r_hs_p1 & ~r_hs_p0;
   assign w_vs_fall = r_vs_p1 & ~r_vs_p0;

   // ---- internal pixel phase and coordinate recovery ----
   logic [PH_W-1:0] r_ph;
   logic [9:0]      r_xi, r_yi;
   logic            w_stb, w_ph_wrap, w_x_wrap;

   assign w_stb     = (r_ph == PH_MID);
   assign w_ph_wrap = (r_ph == PH_LAST);
   assign w_x_wrap  = (r_xi == X_LAST);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_ph <= '0;
         r_xi <= '0;
         r_yi <= '0;
      end else begin
         if (w_hs_fall) begin
            r_ph <= '0;
            r_xi <= X_SYNC;
         end else if (w_ph_wrap) begin
            r_ph <= '0;
            r_xi <= w_x_wrap ? 10'd0 : r_xi + 10'd1;
         end else begin
            r_ph <= r_ph + 1'b1;
         end

         if (w_vs_fall)
            r_yi <= Y_SYNC;
         else if (!w_hs_fall && w_ph_wrap && w_x_wrap)
            r_yi <= (r_yi == Y_LAST) ? 10'd0 : r_yi + 10'd1;
      end
   end

   // ---- line timing check ----
   logic [15:0] r_h_per, r_h_low;
   logic        r_h_seen;
   logic        w_h_err;

   assign w_h_err = w_hs_fall && r_h_seen &&
                    ((r_h_per != H_PER_C) || (r_h_low != H_LOW_C));

   // Both counters restart at 1: the fall cycle itself is the first cycle of period and pulse.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_h_per  <= '0;
         r_h_low  <= '0;
         r_h_seen <= 1'b0;
      end else if (w_hs_fall) begin
         r_h_per  <= 16'd1;
         r_h_low  <= 16'd1;
         r_h_seen <= 1'b1;
      end else begin
         r_h_per <= sat_inc16(r_h_per);
         if (!r_hs_p0)
            r_h_low <= sat_inc16(r_h_low);
      end
   end

   // ---- frame timing check ----
   logic [15:0] r_v_lines, r_v_low;
   logic        r_v_seen;
   logic        w_v_err;

   assign w_v_err = w_vs_fall && r_v_seen &&
                    ((r_v_lines != V_TOT_C) || (r_v_low != V_LOW_C));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_v_lines <= '0;
         r_v_low   <= '0;
         r_v_seen  <= 1'b0;
      end else if (w_vs_fall) begin
         r_v_lines <= {15'd0, w_hs_fall};
         r_v_low   <= {15'd0, w_hs_fall};
         r_v_seen  <= 1'b1;
      end else if (w_hs_fall) begin
         r_v_lines <= sat_inc16(r_v_lines);
         if (!r_vs_p0)
            r_v_low <= sat_inc16(r_v_low);
      end
   end

   // ---- lock state machine ----
   state_t     r_state, w_state_nxt;
   logic [7:0] r_good, w_good_nxt;
   logic       w_err;

   assign w_err = w_h_err | w_v_err;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_UNLOCKED;
         r_good  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_good  <= w_good_nxt;
      end
   end

   // An error coincident with a vs_fall always takes priority over progress toward lock.
   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      case (r_state)
         ST_UNLOCKED: begin
            if (w_vs_fall && !w_err) begin
               w_state_nxt = ST_ACQUIRE;
               w_good_nxt  = 8'd0;
            end
         end
         ST_ACQUIRE: begin
            if (w_err) begin
               w_state_nxt = ST_UNLOCKED;
            end else if (w_vs_fall) begin
               w_good_nxt = r_good + 8'd1;
               if (w_good_nxt >= LOCK_C)
                  w_state_nxt = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (w_err)
               w_state_nxt = ST_UNLOCKED;
         end
         default: begin
            w_state_nxt = ST_UNLOCKED;
         end
      endcase
   end

   // ---- stage p1: registered outputs, probe capture ----
   logic w_locked_i, w_de_i, w_probe_hit;

   assign w_locked_i  = (r_state == ST_LOCKED);
   assign w_de_i      = w_locked_i && (r_xi < X_DISP) && (r_yi < Y_DISP);
   assign w_probe_hit = w_stb && w_locked_i &&
                        (r_xi == bus.probe_x) && (r_yi == bus.probe_y);

   logic [9:0]  r_x_p1, r_y_p1;
   logic        r_stb_p1, r_de_p1, r_locked_p1, r_h_err_p1, r_v_err_p1;
   logic [7:0]  r_err_cnt;
   logic [15:0] r_frame_cnt;
   logic [11:0] r_probe_rgb;
   logic        r_probe_vld_p1;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_x_p1         <= '0;
         r_y_p1         <= '0;
         r_stb_p1       <= 1'b0;
         r_de_p1        <= 1'b0;
         r_locked_p1    <= 1'b0;
         r_h_err_p1     <= 1'b0;
         r_v_err_p1     <= 1'b0;
         r_err_cnt      <= '0;
         r_frame_cnt    <= '0;
         r_probe_rgb    <= '0;
         r_probe_vld_p1 <= 1'b0;
      end else begin
         r_x_p1         <= r_xi;
         r_y_p1         <= r_yi;
         r_stb_p1       <= w_stb;
         r_de_p1        <= w_de_i;
         r_locked_p1    <= w_locked_i;
         r_h_err_p1     <= w_h_err;
         r_v_err_p1     <= w_v_err;
         r_probe_vld_p1 <= w_probe_hit;
         if (w_locked_i && w_err)
            r_err_cnt <= sat_inc8(r_err_cnt);
         if (w_locked_i && w_vs_fall && !w_err)
            r_frame_cnt <= r_frame_cnt + 16'd1;
         if (w_probe_hit)
            r_probe_rgb <= r_rgb_p0;
      end
   end

   assign bus.x           = r_x_p1;
   assign bus.y           = r_y_p1;
   assign bus.pix_stb     = r_stb_p1;
   assign bus.de          = r_de_p1;
   assign bus.locked      = r_locked_p1;
   assign bus.h_err       = r_h_err_p1;
   assign bus.v_err       = r_v_err_p1;
   assign bus.err_cnt     = r_err_cnt;
   assign bus.frame_cnt   = r_frame_cnt;
   assign bus.probe_rgb   = r_probe_rgb;
   assign bus.probe_valid = r_probe_vld_p1;

`ifdef VGA_MON_CRC_EN
   // CRC-16-CCITT, 12 colour bits per active pixel, MSB first.
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] d);
      logic [15:0] v;
      logic        fb;
      v = c;
      for (int i = 11; i >= 0; i--) begin
         fb = v[15] ^ d[i];
         v  = {v[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return v;
   endfunction

   logic [15:0] r_crc, r_frame_crc;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_crc       <= 16'hFFFF;
         r_frame_crc <= '0;
      end else if (w_vs_fall) begin
         r_crc <= 16'hFFFF;
         if (w_locked_i)
            r_frame_crc <= r_crc;
      end else if (w_stb && w_de_i) begin
         r_crc <= crc_step(r_crc, r_rgb_p0);
      end
   end

   assign bus.frame_crc = r_frame_crc;
`else
   assign bus.frame_crc = 16'd0;
`endif

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator: watches the hsync/vsync/rgb pins driven by the display path and recovers pixel coordinates from the wires alone.
- Checks line/frame timing, declares lock, counts frames and errors, and captures the rgb value at a programmable probe coordinate.
- Sits beside the top-level VGA outputs, in sim benches or on-board as a self-check. Its outputs feed the debug sequence display.

Parameters:
H_DISP, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_DISP, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
CLK_PER_PIXEL, 4, sys_clk cycles per pixel (even, >=2)
LOCK_FRAMES, 2, consecutive error-free frames needed to lock

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset, asynchronous, active-low
hsync  in  1  monitored hsync, active-low
vsync  in  1  monitored vsync, active-low
rgb  in  12  monitored pixel colour
probe_x  in  10  probe column
probe_y  in  10  probe row
x  out  10  recovered column
y  out  10  recovered row
pix_stb  out  1  1-cycle pulse at the mid-pixel sample point
de  out  1  locked and x<H_DISP and y<V_DISP
locked  out  1  high in LOCKED state
h_err  out  1  1-cycle pulse on a line-timing violation
v_err  out  1  1-cycle pulse on a frame-timing violation
err_cnt  out  8  lock-loss count, saturating at 255
frame_cnt  out  16  locked frame count, wraps
probe_rgb  out  12  rgb captured at the probe coordinate
probe_valid  out  1  1-cycle pulse after each probe capture
frame_crc  out  16  CRC of the last active frame (optional)

Behaviour:
- Reset: every output 0, all counters 0, state UNLOCKED. Reset asserted mid-frame clears immediately. Relock after release needs LOCK_FRAMES+1 vsync falls.
- Input register stage: hsync, vsync and rgb are registered once (hs_q, vs_q, rgb_q). Edge detection uses hs_q/vs_q against a second delay stage.
- hs_fall cycle:
  - Phase counter ph is set to 0 and x is set to H_DISP+H_FP.
  - ph counts 0..CLK_PER_PIXEL-1, then wraps.
  - pix_stb is high when ph==CLK_PER_PIXEL/2. x, y and rgb_q are valid in that cycle.
  - On each ph wrap, x increments. At H_TOTAL-1, x wraps to 0 and y increments, wrapping at V_TOTAL-1.
  - An hs_fall overrides the increment.
- vs_fall: y is set to V_DISP+V_FP; this overrides any coincident increment. x is unaffected.
- Line check:
  - A 16-bit saturating counter counts sys_clk cycles between hs_falls, and another counts hsync-low cycles.
  - At each hs_fall after the first one following reset, period != H_TOTAL*CLK_PER_PIXEL or low width != H_SYNC*CLK_PER_PIXEL pulses h_err.
- Frame check:
  - Count hs_falls between vs_falls, and count hs_falls while vsync is low.
  - At each vs_fall after the first, line count != V_TOTAL or vsync width != V_SYNC pulses v_err.
  - h_err/v_err pulse in every state.
- State machine:
  - UNLOCKED: on vs_fall, go to ACQUIRE and set good=0.
  - ACQUIRE: any h_err/v_err goes to UNLOCKED. On an error-free vs_fall, good++. When good reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: any h_err/v_err goes to UNLOCKED and increments err_cnt (saturating).
  - Simultaneous error and vs_fall: the error wins.
- frame_cnt increments on each vs_fall while the state is already LOCKED; the transition edge itself does not count.
- de, x, y and locked are registered and update in the cycle after the internal state.
- Probe: when pix_stb, locked, x==probe_x and y==probe_y, then probe_rgb<=rgb_q and probe_valid pulses in the next cycle. A probe outside the active area still captures (blanking value). probe_x/probe_y are sampled at pix_stb; changing them mid-frame takes effect at the next match.

Optional Feature:
- Macro: VGA_MON_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF), fed 12 bits MSB-first of rgb_q on each pix_stb with de high.
  - On vs_fall, frame_crc <= crc and crc <= 0xFFFF. frame_crc updates only while locked.
- Undefined: frame_crc tied to 0 and no CRC logic is generated.

Test Plan:
Bench timing: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), CLK_PER_PIXEL 4, LOCK_FRAMES 2, with a reference generator driving constant rgb=x+16*y.
- Reset, then 4 clean frames -> locked rises at the third vs_fall; h_err=v_err=0; frame_cnt=1 after the fourth vs_fall; err_cnt=0.
- Locked, probe (3,2) -> probe_rgb=0x023 with a probe_valid pulse once per frame; de high exactly 32 pix_stb per frame.
- Locked, stretch one line to 15 pixels -> h_err pulse at the next hs_fall; locked=0; err_cnt=1; relocks after 3 clean vs_falls.
- Locked, vsync width 2 lines -> v_err pulse at the next vs_fall; locked drops; err_cnt=2.
- Assert sys_rst_n low mid-line while locked -> all outputs 0 in the same cycle; after release, locked only at the third vs_fall.
- With VGA_MON_CRC_EN, rgb=0 for all active pixels -> frame_crc equals the model CRC over 32 zero pixels; without the macro, frame_crc=0.
